processor_status_unit: RTL and testbench
========================================

PROCESSOR_STATUS_UNIT -- requirements
Module: processor_status_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of data_in/acc_in; SHALL be >= 2.
REQ-002 Parameter SHADOW_DEPTH, default 4, number of interrupt shadow entries; SHALL be >= 1.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_in  input  DATA_WIDTH  ALU result / memory operand.
REQ-006 acc_in  input  DATA_WIDTH  accumulator value, used only by bit_test.
REQ-007 carry_in, overflow_in  input  1 each  ALU carry / overflow.
REQ-008 update_c, update_z, update_n, update_v  input  1 each  load flag from ALU sources.
REQ-009 flag_op  input  3  0 none, 1 SEC, 2 CLC, 3 SEI, 4 CLI, 5 SED, 6 CLD, 7 CLV.
REQ-010 bit_test  input  1  BIT instruction flag update.
REQ-011 load_p  input  1  load all flags from p_in (PLP).
REQ-012 p_in  input  8  packed status byte.
REQ-013 irq_save  input  1  interrupt entry: push P to shadow stack, set I.
REQ-014 irq_restore  input  1  RTI: pop P from shadow stack.
REQ-015 brk_in  input  1  value placed in p_out bit 4.
REQ-016 flag_c, flag_z, flag_i, flag_d, flag_v, flag_n  output  1 each  current flags.
REQ-017 p_out  output  8  {N,V,1,brk_in,D,I,Z,C}, combinational from flags.
REQ-018 stack_depth  output  clog2(SHADOW_DEPTH+1)  occupied shadow entries.
REQ-019 stack_full, stack_empty  output  1 each  depth==SHADOW_DEPTH / depth==0.
REQ-020 stack_error  output  1  sticky misuse indicator.

Function
REQ-021 All flag changes SHALL take effect one cycle after the requesting input is sampled.
REQ-022 Per-cycle priority SHALL be: reset > irq_restore > load_p > irq_save > flag_op > bit_test > update_*.
REQ-023 irq_restore with depth>0: all six flags SHALL take the top entry, depth decrements; all lower-priority requests ignored.
REQ-024 load_p: C,Z,I,D,V,N SHALL take p_in bits 0,1,2,3,6,7; bits 4,5 ignored; lower-priority requests ignored.
REQ-025 irq_save with depth<SHADOW_DEPTH: pre-edge flags SHALL be pushed, depth increments, flag_i set to 1.
REQ-026 irq_save SHALL force flag_i=1 even if flag_op=CLI same cycle; other flag_op/update_* same cycle SHALL still apply to C,Z,D,V,N.
REQ-027 flag_op SHALL set/clear only its target flag; for that flag it overrides bit_test and update_*.
REQ-028 bit_test: N<=data_in[DATA_WIDTH-1], V<=data_in[DATA_WIDTH-2], Z<=~|(data_in & acc_in); overrides update_n/v/z.
REQ-029 update_z: Z<=~|data_in; update_n: N<=data_in[DATA_WIDTH-1]; update_c: C<=carry_in; update_v: V<=overflow_in.
REQ-030 Flags with no active request SHALL hold.
REQ-031 irq_save when full: no push, depth unchanged, flag_i still set, stack_error set.
REQ-032 irq_restore when empty: flags unchanged, depth unchanged, stack_error set; lower-priority requests still apply.
REQ-033 irq_save and irq_restore same cycle: restore executes, save dropped, stack_error set.
REQ-034 stack_error SHALL remain 1 until reset.
REQ-035 Shadow stack SHALL be LIFO; entries beyond depth are don't-care.

Reset
REQ-036 On reset: C,Z,D,V,N=0, I=1, depth=0, stack_empty=1, stack_full=0, stack_error=0.
REQ-037 Reset asserted mid-sequence SHALL discard all shadow entries and all same-cycle requests.

Verification
REQ-038 Reset, then update_z with data_in=0x00 -> next cycle flag_z=1, p_out=0x26 (brk_in=0).
REQ-039 Flags C=1,N=1; irq_save + flag_op=CLI -> I=1, depth=1; then load_p p_in=0x00 -> flags 0; irq_restore -> C=1,N=1,I=0, depth=0.
REQ-040 DATA_WIDTH=8: bit_test data_in=0xC0, acc_in=0x3F -> N=1,V=1,Z=1; same cycle update_z data_in=0x01 ignored.
REQ-041 SHADOW_DEPTH=2: three irq_save pulses -> depth 2, stack_full=1, stack_error=1; two restores return entries LIFO.
REQ-042 Empty stack: irq_restore + update_c carry_in=1 -> C=1, depth 0, stack_error=1; reset clears stack_error.
REQ-043 DATA_WIDTH=16: update_n data_in=0x8000 -> N=1; update_z data_in=0x0100 -> Z=0.

Source files
------------

// File: rtl/processor_status_unit.sv
// Processor status register (C,Z,I,D,V,N) with a LIFO shadow stack that
// preserves the flags across interrupt entry and RTI.
module processor_status_unit #(
  parameter int DATA_WIDTH   = 8,
  parameter int SHADOW_DEPTH = 4,
  localparam int DEPTH_W     = $clog2(SHADOW_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] acc_in,
  input  logic                  carry_in,
  input  logic                  overflow_in,
  input  logic                  update_c,
  input  logic                  update_z,
  input  logic                  update_n,
  input  logic                  update_v,
  input  logic [2:0]            flag_op,
  input  logic                  bit_test,
  input  logic                  load_p,
  input  logic [7:0]            p_in,
  input  logic                  irq_save,
  input  logic                  irq_restore,
  input  logic                  brk_in,
  output logic                  flag_c,
  output logic                  flag_z,
  output logic                  flag_i,
  output logic                  flag_d,
  output logic                  flag_v,
  output logic                  flag_n,
  output logic [7:0]            p_out,
  output logic [DEPTH_W-1:0]    stack_depth,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  stack_error
);

  typedef enum logic [2:0] {
    OP_NONE, OP_SEC, OP_CLC, OP_SEI, OP_CLI, OP_SED, OP_CLD, OP_CLV
  } flag_op_t;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(SHADOW_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  // Shadow entries are packed {N,V,D,I,Z,C}; entry 0 is always the top.
  logic [5:0]         shadow [SHADOW_DEPTH];
  logic               c_nx, z_nx, i_nx, d_nx, v_nx, n_nx;
  logic [DEPTH_W-1:0] depth_nx;
  logic               error_nx;
  logic               do_push, do_pop;
  logic               unused_p;

  assign unused_p    = ^p_in[5:4];
  assign stack_full  = (stack_depth == DEPTH_MAX);
  assign stack_empty = (stack_depth == '0);
  assign p_out       = {flag_n, flag_v, 1'b1, brk_in, flag_d, flag_i, flag_z, flag_c};

  always_comb begin
    c_nx     = flag_c;
    z_nx     = flag_z;
    i_nx     = flag_i;
    d_nx     = flag_d;
    v_nx     = flag_v;
    n_nx     = flag_n;
    depth_nx = stack_depth;
    error_nx = stack_error;
    do_push  = 1'b0;
    do_pop   = 1'b0;

    if (irq_restore && !stack_empty) begin
      {n_nx, v_nx, d_nx, i_nx, z_nx, c_nx} = shadow[0];
      depth_nx = stack_depth - DEPTH_ONE;
      do_pop   = 1'b1;
      if (irq_save) error_nx = 1'b1;
    end else begin
      if (irq_restore) error_nx = 1'b1;
      if (load_p) begin
        {n_nx, v_nx}               = p_in[7:6];
        {d_nx, i_nx, z_nx, c_nx}   = p_in[3:0];
      end else begin
        // Later assignments win: ALU updates < bit_test < flag_op < irq_save.
        if (update_c) c_nx = carry_in;
        if (update_z) z_nx = ~|data_in;
        if (update_n) n_nx = data_in[DATA_WIDTH-1];
        if (update_v) v_nx = overflow_in;
        if (bit_test) begin
          n_nx = data_in[DATA_WIDTH-1];
          v_nx = data_in[DATA_WIDTH-2];
          z_nx = ~|(data_in & acc_in);
        end
        case (flag_op)
          OP_SEC:  c_nx = 1'b1;
          OP_CLC:  c_nx = 1'b0;
          OP_SEI:  i_nx = 1'b1;
          OP_CLI:  i_nx = 1'b0;
          OP_SED:  d_nx = 1'b1;
          OP_CLD:  d_nx = 1'b0;
          OP_CLV:  v_nx = 1'b0;
          default: ;
        endcase
        if (irq_save && !irq_restore) begin
          i_nx = 1'b1;
          if (stack_full) begin
            error_nx = 1'b1;
          end else begin
            do_push  = 1'b1;
            depth_nx = stack_depth + DEPTH_ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
      flag_i      <= 1'b1;
      flag_d      <= 1'b0;
      flag_v      <= 1'b0;
      flag_n      <= 1'b0;
      stack_depth <= '0;
      stack_error <= 1'b0;
    end else begin
      flag_c      <= c_nx;
      flag_z      <= z_nx;
      flag_i      <= i_nx;
      flag_d      <= d_nx;
      flag_v      <= v_nx;
      flag_n      <= n_nx;
      stack_depth <= depth_nx;
      stack_error <= error_nx;
    end
  end

  // Entry contents need no reset: the depth counter alone marks them valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      shadow[0] <= {flag_n, flag_v, flag_d, flag_i, flag_z, flag_c};
      for (int k = 1; k < SHADOW_DEPTH; k++) shadow[k] <= shadow[k-1];
    end else if (do_pop) begin
      for (int k = 0; k < SHADOW_DEPTH - 1; k++) shadow[k] <= shadow[k+1];
    end
  end

endmodule

// File: tb/tb_processor_status_unit.sv
// Bench for processor_status_unit: an 8-bit/2-deep and a 16-bit/4-deep
// instance share stimulus and are checked against a behavioural model.
module tb_processor_status_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_v, acc_v;
  logic        carry_in, overflow_in;
  logic        update_c, update_z, update_n, update_v;
  logic [2:0]  flag_op;
  logic        bit_test, load_p;
  logic [7:0]  p_in;
  logic        irq_save, irq_restore, brk_in;

  logic       a_c, a_z, a_i, a_d, a_v, a_n, a_full, a_empty, a_err;
  logic [7:0] a_p;
  logic [1:0] a_depth;
  logic       b_c, b_z, b_i, b_d, b_v, b_n, b_full, b_empty, b_err;
  logic [7:0] b_p;
  logic [2:0] b_depth;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference state per instance: 0 = 8-bit/2-deep, 1 = 16-bit/4-deep.
  bit         mc[2], mz[2], mi[2], md[2], mv[2], mn[2], merr[2];
  int         mdepth[2];
  bit [5:0]   mstack[2][8];
  int         wid[2] = '{8, 16};
  int         cap[2] = '{2, 4};

  always #5 clk = ~clk;

  processor_status_unit #(.DATA_WIDTH(8), .SHADOW_DEPTH(2)) dut_a (
    .clk(clk), .reset(reset), .data_in(data_v[7:0]), .acc_in(acc_v[7:0]),
    .carry_in(carry_in), .overflow_in(overflow_in),
    .update_c(update_c), .update_z(update_z), .update_n(update_n), .update_v(update_v),
    .flag_op(flag_op), .bit_test(bit_test), .load_p(load_p), .p_in(p_in),
    .irq_save(irq_save), .irq_restore(irq_restore), .brk_in(brk_in),
    .flag_c(a_c), .flag_z(a_z), .flag_i(a_i), .flag_d(a_d), .flag_v(a_v), .flag_n(a_n),
    .p_out(a_p), .stack_depth(a_depth), .stack_full(a_full), .stack_empty(a_empty),
    .stack_error(a_err)
  );

  processor_status_unit #(.DATA_WIDTH(16), .SHADOW_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .data_in(data_v), .acc_in(acc_v),
    .carry_in(carry_in), .overflow_in(overflow_in),
    .update_c(update_c), .update_z(update_z), .update_n(update_n), .update_v(update_v),
    .flag_op(flag_op), .bit_test(bit_test), .load_p(load_p), .p_in(p_in),
    .irq_save(irq_save), .irq_restore(irq_restore), .brk_in(brk_in),
    .flag_c(b_c), .flag_z(b_z), .flag_i(b_i), .flag_d(b_d), .flag_v(b_v), .flag_n(b_n),
    .p_out(b_p), .stack_depth(b_depth), .stack_full(b_full), .stack_empty(b_empty),
    .stack_error(b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next state of one model instance given the inputs currently applied.
  task automatic model_step(input int m);
    int         w;
    logic [15:0] mask, d, a;
    bit [5:0]   pre;
    w    = wid[m];
    mask = 16'((32'h1 << w) - 1);
    d    = data_v & mask;
    a    = acc_v & mask;
    pre  = {mn[m], mv[m], md[m], mi[m], mz[m], mc[m]};
    if (reset) begin
      {mn[m], mv[m], md[m], mz[m], mc[m]} = '0;
      mi[m] = 1'b1; mdepth[m] = 0; merr[m] = 1'b0;
      return;
    end
    if (irq_restore && mdepth[m] > 0) begin
      mdepth[m]--;
      {mn[m], mv[m], md[m], mi[m], mz[m], mc[m]} = mstack[m][mdepth[m]];
      if (irq_save) merr[m] = 1'b1;
      return;
    end
    if (irq_restore) merr[m] = 1'b1;
    if (load_p) begin
      mc[m] = p_in[0]; mz[m] = p_in[1]; mi[m] = p_in[2];
      md[m] = p_in[3]; mv[m] = p_in[6]; mn[m] = p_in[7];
      return;
    end
    if (update_c) mc[m] = carry_in;
    if (update_z) mz[m] = (d == 16'h0);
    if (update_n) mn[m] = d[w-1];
    if (update_v) mv[m] = overflow_in;
    if (bit_test) begin
      mn[m] = d[w-1];
      mv[m] = d[w-2];
      mz[m] = ((d & a) == 16'h0);
    end
    case (flag_op)
      3'd1: mc[m] = 1'b1;
      3'd2: mc[m] = 1'b0;
      3'd3: mi[m] = 1'b1;
      3'd4: mi[m] = 1'b0;
      3'd5: md[m] = 1'b1;
      3'd6: md[m] = 1'b0;
      3'd7: mv[m] = 1'b0;
      default: ;
    endcase
    if (irq_save && !irq_restore) begin
      mi[m] = 1'b1;
      if (mdepth[m] < cap[m]) begin
        mstack[m][mdepth[m]] = pre;
        mdepth[m]++;
      end else begin
        merr[m] = 1'b1;
      end
    end
  endtask

  task automatic check_output();
    check("a_flags", {a_n, a_v, a_d, a_i, a_z, a_c}, {mn[0], mv[0], md[0], mi[0], mz[0], mc[0]});
    check("a_p_out", a_p, {mn[0], mv[0], 1'b1, brk_in, md[0], mi[0], mz[0], mc[0]});
    check("a_depth", a_depth, mdepth[0]);
    check("a_full", a_full, mdepth[0] == cap[0]);
    check("a_empty", a_empty, mdepth[0] == 0);
    check("a_error", a_err, merr[0]);
    check("b_flags", {b_n, b_v, b_d, b_i, b_z, b_c}, {mn[1], mv[1], md[1], mi[1], mz[1], mc[1]});
    check("b_p_out", b_p, {mn[1], mv[1], 1'b1, brk_in, md[1], mi[1], mz[1], mc[1]});
    check("b_depth", b_depth, mdepth[1]);
    check("b_full", b_full, mdepth[1] == cap[1]);
    check("b_empty", b_empty, mdepth[1] == 0);
    check("b_error", b_err, merr[1]);
  endtask

  task automatic idle();
    reset = 1'b0; data_v = '0; acc_v = '0; carry_in = 1'b0; overflow_in = 1'b0;
    update_c = 1'b0; update_z = 1'b0; update_n = 1'b0; update_v = 1'b0;
    flag_op = 3'd0; bit_test = 1'b0; load_p = 1'b0; p_in = '0;
    irq_save = 1'b0; irq_restore = 1'b0; brk_in = 1'b0;
  endtask

  // Predict, clock once, compare, then return inputs to idle.
  task automatic apply_stimulus();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_output();
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1; apply_stimulus();
    check("reset_p_a", a_p, 8'h24);

    update_z = 1'b1; data_v = 16'h0000; apply_stimulus();
    check("zero_p_a", a_p, 8'h26);

    reset = 1'b1; apply_stimulus();
    update_c = 1'b1; carry_in = 1'b1; update_n = 1'b1; data_v = 16'h8080; flag_op = 3'd4;
    apply_stimulus();
    check("cn_set_p_a", a_p, 8'hA1);
    irq_save = 1'b1; flag_op = 3'd4; apply_stimulus();
    check("save_cli_i_a", a_i, 1'b1);
    check("save_depth_a", a_depth, 2'd1);
    load_p = 1'b1; p_in = 8'h00; apply_stimulus();
    check("plp_p_a", a_p, 8'h20);
    irq_restore = 1'b1; apply_stimulus();
    check("rti_p_a", a_p, 8'hA1);
    check("rti_depth_a", a_depth, 2'd0);

    bit_test = 1'b1; update_z = 1'b1; data_v = 16'h00C0; acc_v = 16'h003F; apply_stimulus();
    check("bit_p_a", a_p, 8'hE3);

    reset = 1'b1; apply_stimulus();
    flag_op = 3'd4; apply_stimulus();
    irq_save = 1'b1; flag_op = 3'd1; apply_stimulus();
    check("push1_p_a", a_p, 8'h25);
    irq_save = 1'b1; flag_op = 3'd5; apply_stimulus();
    check("push2_p_a", a_p, 8'h2D);
    irq_save = 1'b1; apply_stimulus();
    check("overflow_depth_a", a_depth, 2'd2);
    check("overflow_full_a", a_full, 1'b1);
    check("overflow_err_a", a_err, 1'b1);
    irq_restore = 1'b1; apply_stimulus();
    check("pop1_p_a", a_p, 8'h25);
    irq_restore = 1'b1; apply_stimulus();
    check("pop2_p_a", a_p, 8'h20);
    check("pop2_empty_a", a_empty, 1'b1);

    reset = 1'b1; apply_stimulus();
    irq_restore = 1'b1; update_c = 1'b1; carry_in = 1'b1; apply_stimulus();
    check("underflow_c_a", a_c, 1'b1);
    check("underflow_err_a", a_err, 1'b1);
    reset = 1'b1; apply_stimulus();
    check("reset_err_a", a_err, 1'b0);

    update_n = 1'b1; data_v = 16'h8000; apply_stimulus();
    check("n16_b", b_n, 1'b1);
    update_z = 1'b1; data_v = 16'h0100; apply_stimulus();
    check("z16_b", b_z, 1'b0);
    check("z8_a", a_z, 1'b1);

    brk_in = 1'b1; #1;
    check("brk_bit_a", a_p[4], 1'b1);
    idle();

    for (int k = 0; k < 600; k++) begin
      reset       = ($urandom_range(99) < 2);
      data_v      = ($urandom_range(7) == 0) ? 16'h0 : 16'($urandom);
      acc_v       = 16'($urandom);
      carry_in    = 1'($urandom);
      overflow_in = 1'($urandom);
      update_c    = ($urandom_range(99) < 40);
      update_z    = ($urandom_range(99) < 40);
      update_n    = ($urandom_range(99) < 40);
      update_v    = ($urandom_range(99) < 40);
      flag_op     = ($urandom_range(1) == 0) ? 3'd0 : 3'($urandom);
      bit_test    = ($urandom_range(99) < 20);
      load_p      = ($urandom_range(99) < 8);
      p_in        = 8'($urandom);
      irq_save    = ($urandom_range(99) < 25);
      irq_restore = ($urandom_range(99) < 15);
      brk_in      = 1'($urandom);
      apply_stimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
